// File: rtl/boa_extmem_pkg.sv
// boa_extmem_pkg: state type and beat helpers shared by the wide external SRAM bridge
package boa_extmem_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  // One bit per external beat, set when that beat's strobe slice has any byte enabled
  function automatic logic [3:0] slice_mask(input logic [3:0] we, input int bpb);
    slice_mask = '0;
    for (int i = 0; i < 4; i++)
      if (i < 4 / bpb) slice_mask[i] = |(we & 4'(((1 << bpb) - 1) << (i * bpb)));
  endfunction
  function automatic logic [2:0] beat_count(input logic [3:0] we, input int bpb);
    logic [3:0] m;
    m = slice_mask(we, bpb);
    beat_count = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction
  function automatic logic [1:0] first_beat(input logic [3:0] m);
    first_beat = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) first_beat = 2'(i);
  endfunction
endpackage

// File: rtl/boa_mem_bus.sv
// boa_mem_bus: 32-bit word memory bus between a master and a RAM-side slave
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  modport ram (input re, we, addr, wdata, output ready, rdata);
  modport cpu (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_extmem_waitctr.sv
// boa_extmem_waitctr: wait-state down-counter; zero marks the final cycle of a beat
module boa_extmem_waitctr #(
  parameter int w = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [w-1:0] val,
  input  logic         tick,
  output logic         zero
);
  logic [w-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (tick && !zero) cnt <= cnt - w'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/boa_extmem_sram_wide.sv
// boa_extmem_sram_wide: splits 32-bit bus words into little-endian beats on a narrow external SRAM
module boa_extmem_sram_wide
  import boa_extmem_pkg::*;
#(
  parameter int alen        = 16,
  parameter int dwidth      = 8,
  parameter int wait_states = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  boa_mem_bus.ram             bus,
  output logic                xm_re,
  output logic                xm_we,
  output logic [alen-1:0]     xm_addr,
  output logic [dwidth/8-1:0] xm_be,
  output logic [dwidth-1:0]   xm_wdata,
  input  logic [dwidth-1:0]   xm_rdata
);
  localparam int bpb = dwidth / 8;
  localparam int kb  = 2 - $clog2(bpb);
  if (!(dwidth == 8 || dwidth == 16 || dwidth == 32)) begin : g_bad_dwidth
    $error("boa_extmem_sram_wide: dwidth must be 8, 16 or 32");
  end
  if (wait_states < 0 || wait_states > 7) begin : g_bad_ws
    $error("boa_extmem_sram_wide: wait_states must be 0..7");
  end
  state_t      state;
  logic [1:0]  k, sk;
  logic [3:0]  pend, smask, swe, we_l;
  logic [2:0]  left;
  logic        is_wr, swr, zero, start, beat_end, last, load, tick, unused_addr;
  logic [31:0] addr_l, wd_l, saddr, swd, rbuf, rnext, rdata;
  assign start    = state == IDLE && (|bus.we || bus.re);
  assign beat_end = state == BEAT && zero;
  assign last     = left == 3'd1;
  assign load     = start || (beat_end && !last);
  assign tick     = state == BEAT && !zero;
  // In IDLE the next beat comes straight off the bus; afterwards from the latched request
  assign swr   = state == IDLE ? |bus.we : is_wr;
  assign swe   = state == IDLE ? (|bus.we ? bus.we : 4'hf) : we_l;
  assign saddr = state == IDLE ? bus.addr : addr_l;
  assign swd   = state == IDLE ? bus.wdata : wd_l;
  assign smask = slice_mask(swe, bpb);
  assign sk    = state == IDLE ? first_beat(smask) : first_beat(pend);
  assign unused_addr = ^saddr[1:0];
  always_comb begin
    rnext = rbuf;
    rnext[int'(k) * dwidth +: dwidth] = xm_rdata;
  end
  boa_extmem_waitctr #(.w(3)) u_waitctr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .val  (3'(wait_states)),
    .tick (tick),
    .zero (zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      pend     <= '0;
      left     <= '0;
      is_wr    <= 1'b0;
      addr_l   <= '0;
      we_l     <= '0;
      wd_l     <= '0;
      rbuf     <= '0;
      rdata    <= '0;
      xm_re    <= 1'b0;
      xm_we    <= 1'b0;
      xm_addr  <= '0;
      xm_be    <= '0;
      xm_wdata <= '0;
    end else if (load) begin
      state    <= BEAT;
      k        <= sk;
      pend     <= (start ? smask : pend) & ~(4'd1 << sk);
      left     <= start ? beat_count(swe, bpb) : left - 3'd1;
      is_wr    <= swr;
      addr_l   <= saddr;
      we_l     <= swe;
      wd_l     <= swd;
      xm_re    <= !swr;
      xm_we    <= swr;
      xm_addr  <= (alen'(saddr[31:2]) << kb) | alen'(sk);
      xm_be    <= swe[int'(sk) * bpb +: bpb];
      xm_wdata <= swd[int'(sk) * dwidth +: dwidth];
      if (beat_end && !is_wr) rbuf <= rnext;
    end else if (beat_end) begin
      state <= DONE;
      xm_re <= 1'b0;
      xm_we <= 1'b0;
      if (!is_wr) begin
        rbuf  <= rnext;
        rdata <= rnext;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign bus.ready = state == DONE;
  assign bus.rdata = rdata;
endmodule

// File: tb/tb_boa_extmem_sram_wide.sv
// tb_boa_extmem_sram_wide: randomized scoreboard bench driving an 8-bit/0-wait and a 16-bit/2-wait bridge
module tb_boa_extmem_sram_wide;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boa_mem_bus bus_a ();
  boa_mem_bus bus_b ();
  logic        a_re, a_we, b_re, b_we;
  logic [15:0] a_addr, b_addr;
  logic [0:0]  a_be;
  logic [1:0]  b_be;
  logic [7:0]  a_wd, a_rd;
  logic [15:0] b_wd, b_rd;

  boa_extmem_sram_wide #(.alen(16), .dwidth(8), .wait_states(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .xm_re(a_re), .xm_we(a_we), .xm_addr(a_addr),
    .xm_be(a_be), .xm_wdata(a_wd), .xm_rdata(a_rd));
  boa_extmem_sram_wide #(.alen(16), .dwidth(16), .wait_states(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .xm_re(b_re), .xm_we(b_we), .xm_addr(b_addr),
    .xm_be(b_be), .xm_wdata(b_wd), .xm_rdata(b_rd));

  // External SRAMs: each unit starts out holding its own address (loopback pattern)
  logic [7:0]  mem_a [0:1023];
  logic [15:0] mem_b [0:511];
  logic        mem_init = 1'b0;
  assign a_rd = mem_a[a_addr[9:0]];
  assign b_rd = mem_b[b_addr[8:0]];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 8'(i);
      for (int i = 0; i < 512; i++) mem_b[i] <= 16'(i);
      mem_init <= 1'b1;
    end else begin
      if (a_we && a_be[0]) mem_a[a_addr[9:0]] <= a_wd;
      if (b_we && b_be[0]) mem_b[b_addr[8:0]][7:0] <= b_wd[7:0];
      if (b_we && b_be[1]) mem_b[b_addr[8:0]][15:8] <= b_wd[15:8];
    end
  end

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  int          cur = 0;
  logic        rec = 1'b0;
  beat_t       obs[$];
  logic [7:0]  rmem [2][1024];
  logic [31:0] prev_rd [2];

  always @(negedge clk) begin
    if (rec && cur == 0 && (a_re || a_we)) obs.push_back({a_we, a_addr, 4'(a_be), a_we ? 32'(a_wd) : 32'd0});
    if (rec && cur == 1 && (b_re || b_we)) obs.push_back({b_we, b_addr, 4'(b_be), b_we ? 32'(b_wd) : 32'd0});
  end

  task automatic drive(input int d, input logic re, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      bus_a.re = re; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wd;
    end else begin
      bus_b.re = re; bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return d == 0 ? bus_a.ready : bus_b.ready;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return d == 0 ? bus_a.rdata : bus_b.rdata;
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [31:0] w);
    return {rmem[d][int'(4 * w + 3)], rmem[d][int'(4 * w + 2)], rmem[d][int'(4 * w + 1)], rmem[d][int'(4 * w)]};
  endfunction

  // One full bus access with a cycle-by-cycle comparison of the external beat stream
  task automatic do_txn(input int d, input logic re, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input string name);
    int dw, ws, bpb, nb, n, lat, exp_lat;
    logic wr, bad;
    logic [31:0] w, exp_rd;
    beat_t expq[$];
    dw = d ? 16 : 8;
    ws = d ? 2 : 0;
    bpb = dw / 8;
    nb = 4 / bpb;
    wr = |we;
    w = addr >> 2;
    n = 0;
    for (int k = 0; k < nb; k++) begin
      logic [3:0] sl, be;
      sl = (we >> (k * bpb)) & 4'((1 << bpb) - 1);
      if (!(wr && sl == 4'd0)) begin
        be = wr ? sl : 4'((1 << bpb) - 1);
        n++;
        for (int c = 0; c <= ws; c++)
          expq.push_back({wr, 16'(w * nb + k), be, wr ? 32'((wd >> (k * dw)) & ((32'd1 << dw) - 32'd1)) : 32'd0});
      end
    end
    exp_lat = n * (ws + 1) + 1;
    exp_rd = wr ? prev_rd[d] : ref_word(d, w);
    @(negedge clk);
    cur = d;
    obs.delete();
    rec = 1'b1;
    drive(d, re, we, addr, wd);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, 4'd0, $urandom, $urandom);
    lat = 1;
    while (!rdy(d) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!rdy(d)) begin
      failures++;
      $display("FAIL %s ready_timeout: no ready after %0d cycles, required by %0d", name, lat, exp_lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
      end
      checks++;
      if (rdat(d) !== exp_rd) begin
        failures++;
        $display("FAIL %s rdata: got %h, expected %h", name, rdat(d), exp_rd);
      end
    end
    @(negedge clk);
    checks++;
    if (rdy(d) !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_width: ready still %b one cycle later, expected 0", name, rdy(d));
    end
    rec = 1'b0;
    bad = obs.size() != expq.size();
    for (int i = 0; i < obs.size() && !bad; i++) bad = obs[i] !== expq[i];
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s beats: got %0d beat cycles, expected %0d (first got %h, expected %h)",
               name, obs.size(), expq.size(), obs.size() ? obs[0] : '0, expq.size() ? expq[0] : '0);
    end
    prev_rd[d] = exp_rd;
    if (wr) for (int j = 0; j < 4; j++) if (we[j]) rmem[d][int'(4 * w) + j] = wd[8 * j +: 8];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_re, a_we, a_addr, a_be, a_wd, bus_a.ready, bus_a.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_a: got re=%b we=%b addr=%h be=%b wd=%h ready=%b rdata=%h, expected all 0",
               a_re, a_we, a_addr, a_be, a_wd, bus_a.ready, bus_a.rdata);
    end
    checks++;
    if ({b_re, b_we, b_addr, b_be, b_wd, bus_b.ready, bus_b.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_b: got re=%b we=%b addr=%h be=%b wd=%h ready=%b rdata=%h, expected all 0",
               b_re, b_we, b_addr, b_be, b_wd, bus_b.ready, bus_b.rdata);
    end
  endtask

  task automatic test_read8_loopback();
    do_txn(0, 1'b1, 4'd0, 32'h12, 32'd0, "read8_loopback");
    checks++;
    if (bus_a.rdata !== 32'h13121110) begin
      failures++;
      $display("FAIL read8_word: got %h, expected 13121110", bus_a.rdata);
    end
  endtask

  task automatic test_write8();
    do_txn(0, 1'b0, 4'hf, 32'h10, 32'hdeadbeef, "write8_full");
    checks++;
    if ({mem_a[19], mem_a[18], mem_a[17], mem_a[16]} !== 32'hdeadbeef) begin
      failures++;
      $display("FAIL write8_sram: got %h, expected deadbeef", {mem_a[19], mem_a[18], mem_a[17], mem_a[16]});
    end
  endtask

  task automatic test_sparse_write();
    do_txn(0, 1'b0, 4'b0101, 32'h0, 32'h11223344, "write8_sparse");
    do_txn(1, 1'b0, 4'b1100, 32'h44, 32'hcafe0000, "write16_upper");
  endtask

  task automatic test_priority();
    do_txn(0, 1'b1, 4'hf, 32'h40, $urandom, "read_write_priority8");
    do_txn(1, 1'b1, 4'b0011, 32'h48, $urandom, "read_write_priority16");
  endtask

  task automatic test_wide_read();
    do_txn(1, 1'b1, 4'd0, 32'h20, 32'd0, "read16_ws2");
    checks++;
    if (bus_b.rdata !== 32'h00110010) begin
      failures++;
      $display("FAIL read16_word: got %h, expected 00110010", bus_b.rdata);
    end
  endtask

  // A read held through DONE must only be taken again from the following IDLE cycle
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h8, 32'd0);
    n = 0;
    while (!bus_a.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (a_re !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_accept: xm_re=%b in cycle after DONE, expected 0", a_re);
    end
    @(negedge clk);
    checks++;
    if (a_re !== 1'b1 || a_addr !== 16'h8) begin
      failures++;
      $display("FAIL b2b_idle_accept: xm_re=%b addr=%h, expected 1 and 0008", a_re, a_addr);
    end
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    n = 0;
    while (!bus_a.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_a.ready !== 1'b1 || bus_a.rdata !== ref_word(0, 32'd2)) begin
      failures++;
      $display("FAIL b2b_second: ready=%b rdata=%h, expected 1 and %h", bus_a.ready, bus_a.rdata, ref_word(0, 32'd2));
    end
    prev_rd[0] = ref_word(0, 32'd2);
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    logic saw;
    @(negedge clk);
    drive(0, 1'b1, 4'd0, 32'h30, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_re !== 1'b1 || a_addr !== 16'h32) begin
      failures++;
      $display("FAIL midread_beat2: xm_re=%b addr=%h, expected 1 and 0032", a_re, a_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_re, a_we, a_addr, a_be, a_wd, bus_a.ready, bus_a.rdata} !== '0) begin
      failures++;
      $display("FAIL midread_reset: got re=%b addr=%h be=%b wd=%h ready=%b rdata=%h, expected all 0",
               a_re, a_addr, a_be, a_wd, bus_a.ready, bus_a.rdata);
    end
    saw = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw |= bus_a.ready;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL midread_no_ready: ready pulse seen=%b after abort, expected 0", saw);
    end
    prev_rd[0] = 32'd0;
    prev_rd[1] = 32'd0;
    do_txn(0, 1'b1, 4'd0, 32'h30, 32'd0, "read_after_abort");
  endtask

  task automatic test_random();
    logic [3:0] we;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 25; i++) begin
        we = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom);
        do_txn(d, we == 4'd0 ? 1'b1 : 1'($urandom), we, {22'd0, 8'($urandom), 2'($urandom)}, $urandom,
               $sformatf("random_d%0d_%0d", d, i));
      end
  endtask

  initial begin
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    prev_rd[0] = 32'd0;
    prev_rd[1] = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      rmem[0][i] = 8'(i);
      rmem[1][i] = (i % 2) ? 8'((i / 2) >> 8) : 8'(i / 2);
    end
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_read8_loopback();
    test_write8();
    test_sparse_write();
    test_priority();
    test_wide_read();
    test_back_to_back();
    test_reset_midread();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
